// File: rtl/sme_feeder.sv
// rtl/sme_feeder.sv - host-side buffer and sequencer feeding the string-matching engine
//
// Buffers one string (STR_MAX chars) and one pattern (PAT_MAX chars) written by
// a host, streams them onto the engine input bus on start, then captures the
// engine result or aborts after TIMEOUT idle cycles.
//
// Ports:
//   clk, reset             clock, asynchronous active-high reset
//   str_wr, pat_wr,wr_data host character writes (accepted only when idle)
//   clr_str                empty the string buffer (wins over str_wr)
//   start, send_str        launch a job; send_str=0 reuses the engine's string
//   valid, match,
//   match_index            engine result strobe and payload
//   chardata, isstring,
//   ispattern              engine input bus (registered)
//   busy, done             job in progress / one-cycle result pulse
//   res_match, res_index,
//   res_err                captured result, held until the next job completes
module sme_feeder #(
  parameter int STR_MAX = 32,
  parameter int PAT_MAX = 8,
  parameter int TIMEOUT = 255
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       str_wr,
  input  logic       pat_wr,
  input  logic [7:0] wr_data,
  input  logic       clr_str,
  input  logic       start,
  input  logic       send_str,
  input  logic       valid,
  input  logic       match,
  input  logic [4:0] match_index,
  output logic [7:0] chardata,
  output logic       isstring,
  output logic       ispattern,
  output logic       busy,
  output logic       done,
  output logic       res_match,
  output logic [4:0] res_index,
  output logic       res_err
);

  localparam int SLW = $clog2(STR_MAX + 1);
  localparam int PLW = $clog2(PAT_MAX + 1);
  localparam int SAW = $clog2(STR_MAX);
  localparam int PAW = $clog2(PAT_MAX);
  localparam logic [SLW-1:0] STR_FULL  = SLW'(STR_MAX);
  localparam logic [PLW-1:0] PAT_FULL  = PLW'(PAT_MAX);
  localparam logic [7:0]     WAIT_LAST = 8'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SEND_STR,
    S_SEND_PAT,
    S_WAIT_RES,
    S_DONE
  } state_t;

  state_t         state_q, state_d;
  logic [SLW-1:0] str_len_q, str_len_d;
  logic [PLW-1:0] pat_len_q, pat_len_d;
  logic [SLW-1:0] idx_q, idx_d;
  logic [7:0]     cnt_q, cnt_d;
  logic [7:0]     chardata_q, chardata_d;
  logic           isstring_q, isstring_d;
  logic           ispattern_q, ispattern_d;
  logic           busy_q, busy_d;
  logic           done_q, done_d;
  logic           res_match_q, res_match_d;
  logic [4:0]     res_index_q, res_index_d;
  logic           res_err_q, res_err_d;
  logic           str_we, pat_we;

  logic [7:0] str_mem [STR_MAX];
  logic [7:0] pat_mem [PAT_MAX];

  // Buffer storage needs no reset: lengths alone define valid contents.
  always_ff @(posedge clk) begin
    if (str_we) str_mem[str_len_q[SAW-1:0]] <= wr_data;
    if (pat_we) pat_mem[pat_len_q[PAW-1:0]] <= wr_data;
  end

  always_comb begin
    state_d     = state_q;
    str_len_d   = str_len_q;
    pat_len_d   = pat_len_q;
    idx_d       = idx_q;
    cnt_d       = cnt_q;
    done_d      = 1'b0;
    res_match_d = res_match_q;
    res_index_d = res_index_q;
    res_err_d   = res_err_q;
    str_we      = 1'b0;
    pat_we      = 1'b0;

    if (state_q == S_IDLE) begin
      if (clr_str) begin
        str_len_d = '0;
      end else if (str_wr && str_len_q != STR_FULL) begin
        str_we    = 1'b1;
        str_len_d = str_len_q + SLW'(1);
      end
      if (pat_wr && pat_len_q != PAT_FULL) begin
        pat_we    = 1'b1;
        pat_len_d = pat_len_q + PLW'(1);
      end
    end

    case (state_q)
      S_IDLE: begin
        if (start) begin
          idx_d = '0;
          if (pat_len_q == '0 || (send_str && str_len_q == '0)) begin
            state_d     = S_DONE;
            done_d      = 1'b1;
            res_match_d = 1'b0;
            res_index_d = '0;
            res_err_d   = 1'b1;
          end else begin
            state_d = send_str ? S_SEND_STR : S_SEND_PAT;
          end
        end
      end
      S_SEND_STR: begin
        if (idx_q + SLW'(1) == str_len_q) begin
          state_d = S_SEND_PAT;
          idx_d   = '0;
        end else begin
          idx_d = idx_q + SLW'(1);
        end
      end
      S_SEND_PAT: begin
        if (idx_q + SLW'(1) == SLW'(pat_len_q)) begin
          state_d = S_WAIT_RES;
          cnt_d   = '0;
        end else begin
          idx_d = idx_q + SLW'(1);
        end
      end
      S_WAIT_RES: begin
        if (valid) begin
          state_d     = S_DONE;
          done_d      = 1'b1;
          res_match_d = match;
          res_index_d = match_index;
          res_err_d   = 1'b0;
        end else if (cnt_q == WAIT_LAST) begin
          state_d     = S_DONE;
          done_d      = 1'b1;
          res_match_d = 1'b0;
          res_index_d = '0;
          res_err_d   = 1'b1;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      S_DONE: begin
        // String is kept so a later job can run with send_str=0.
        pat_len_d = '0;
        state_d   = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Bus and busy are registered from the current state, so they trail the
  // state register by one cycle; the last pattern character is therefore on
  // the bus during the first WAIT_RES cycle.
  always_comb begin
    chardata_d  = 8'd0;
    isstring_d  = 1'b0;
    ispattern_d = 1'b0;
    busy_d      = (state_q != S_IDLE);
    if (state_q == S_SEND_STR) begin
      isstring_d = 1'b1;
      chardata_d = str_mem[idx_q[SAW-1:0]];
    end else if (state_q == S_SEND_PAT) begin
      ispattern_d = 1'b1;
      chardata_d  = pat_mem[idx_q[PAW-1:0]];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= S_IDLE;
      str_len_q   <= '0;
      pat_len_q   <= '0;
      idx_q       <= '0;
      cnt_q       <= '0;
      chardata_q  <= '0;
      isstring_q  <= 1'b0;
      ispattern_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      res_match_q <= 1'b0;
      res_index_q <= '0;
      res_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      str_len_q   <= str_len_d;
      pat_len_q   <= pat_len_d;
      idx_q       <= idx_d;
      cnt_q       <= cnt_d;
      chardata_q  <= chardata_d;
      isstring_q  <= isstring_d;
      ispattern_q <= ispattern_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      res_match_q <= res_match_d;
      res_index_q <= res_index_d;
      res_err_q   <= res_err_d;
    end
  end

  assign chardata  = chardata_q;
  assign isstring  = isstring_q;
  assign ispattern = ispattern_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign res_match = res_match_q;
  assign res_index = res_index_q;
  assign res_err   = res_err_q;

endmodule

// File: tb/tb_sme_feeder.sv
// tb/tb_sme_feeder.sv - directed self-checking bench for sme_feeder
module tb_sme_feeder;
  logic       clk = 1'b0;
  logic       reset, str_wr, pat_wr, clr_str, start, send_str;
  logic       valid, match;
  logic [7:0] wr_data;
  logic [4:0] match_index;
  logic [7:0] chardata;
  logic       isstring, ispattern, busy, done, res_match, res_err;
  logic [4:0] res_index;

  int checks = 0;
  int failures = 0;

  sme_feeder dut (
    .clk(clk), .reset(reset), .str_wr(str_wr), .pat_wr(pat_wr),
    .wr_data(wr_data), .clr_str(clr_str), .start(start), .send_str(send_str),
    .valid(valid), .match(match), .match_index(match_index),
    .chardata(chardata), .isstring(isstring), .ispattern(ispattern),
    .busy(busy), .done(done), .res_match(res_match), .res_index(res_index),
    .res_err(res_err)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wr_str(input logic [7:0] c);
    str_wr = 1'b1; wr_data = c; tick(); str_wr = 1'b0;
  endtask

  task automatic wr_pat(input logic [7:0] c);
    pat_wr = 1'b1; wr_data = c; tick(); pat_wr = 1'b0;
  endtask

  task automatic launch(input logic ss);
    start = 1'b1; send_str = ss; tick(); start = 1'b0; send_str = 1'b0;
  endtask

  task automatic reply(input logic m, input logic [4:0] ix);
    valid = 1'b1; match = m; match_index = ix; tick();
    valid = 1'b0; match = 1'b0; match_index = '0;
  endtask

  initial begin
    string s1, p1, p2;
    int scount, pcount, bad, n;
    s1 = "abcde"; p1 = "cd"; p2 = "xy";
    reset = 1'b1; str_wr = 0; pat_wr = 0; clr_str = 0; start = 0; send_str = 0;
    valid = 0; match = 0; wr_data = '0; match_index = '0;
    tick(); tick();
    check("rst_outputs", {chardata, isstring, ispattern, busy, done, res_match, res_index, res_err}, '0);
    reset = 1'b0;
    tick();

    // Job 1: string "abcde", pattern "cd"
    for (int k = 0; k < 5; k++) wr_str(s1[k]);
    for (int k = 0; k < 2; k++) wr_pat(p1[k]);
    launch(1'b1);
    check("j1_bus_idle_at_T", {isstring, ispattern}, 2'b00);
    for (int k = 0; k < 5; k++) begin
      tick();
      check($sformatf("j1_str%0d", k), {busy, isstring, ispattern, chardata}, {3'b110, s1[k]});
    end
    for (int k = 0; k < 2; k++) begin
      tick();
      check($sformatf("j1_pat%0d", k), {isstring, ispattern, chardata}, {2'b01, p1[k]});
    end
    tick();
    check("j1_bus_quiet", {isstring, ispattern, chardata}, '0);
    reply(1'b1, 5'd2);
    check("j1_result", {done, res_match, res_index, res_err}, {1'b1, 1'b1, 5'd2, 1'b0});
    tick();
    check("j1_done_pulse", done, 1'b0);
    tick();
    check("j1_busy_clear", busy, 1'b0);

    // Job 2: pattern only against retained string
    for (int k = 0; k < 2; k++) wr_pat(p2[k]);
    launch(1'b0);
    for (int k = 0; k < 2; k++) begin
      tick();
      check($sformatf("j2_pat%0d", k), {isstring, ispattern, chardata}, {2'b01, p2[k]});
    end
    tick();
    check("j2_bus_quiet", {isstring, ispattern}, 2'b00);
    reply(1'b0, 5'd7);
    check("j2_result", {done, res_match, res_index, res_err}, {1'b1, 1'b0, 5'd7, 1'b0});
    tick(); tick();

    // Job 3: empty pattern -> immediate error, no bus activity
    launch(1'b0);
    check("j3_err", {done, res_match, res_index, res_err}, {1'b1, 1'b0, 5'd0, 1'b1});
    tick();
    check("j3_no_bus", {done, isstring, ispattern}, 3'b000);
    tick();

    // Job 4: 33 string writes saturate at 32; pat_wr while busy is dropped
    clr_str = 1'b1; tick(); clr_str = 1'b0;
    for (int k = 0; k < 33; k++) wr_str(8'h40 + 8'(k));
    wr_pat(8'h5a);
    launch(1'b1);
    scount = 0; pcount = 0; bad = 0;
    for (int k = 0; k < 40; k++) begin
      pat_wr = (k == 3); wr_data = 8'h21;
      tick();
      if (isstring) begin
        if (chardata !== 8'h40 + 8'(scount)) bad++;
        scount++;
      end
      if (ispattern) begin
        if (chardata !== 8'h5a) bad++;
        pcount++;
      end
    end
    pat_wr = 1'b0;
    check("j4_str_count", scount, 32);
    check("j4_pat_count", pcount, 1);
    check("j4_char_errors", bad, 0);
    reply(1'b1, 5'd31);
    check("j4_result", {done, res_match, res_index, res_err}, {1'b1, 1'b1, 5'd31, 1'b0});
    tick(); tick();

    // Job 5: no engine reply -> timeout after 255 WAIT_RES cycles
    wr_pat(8'h71);
    launch(1'b0);
    n = 0;
    while (!done && n < 400) begin
      tick();
      n++;
    end
    check("j5_timeout_cycles", n, 256);
    check("j5_result", {done, res_match, res_index, res_err}, {1'b1, 1'b0, 5'd0, 1'b1});
    tick(); tick();

    // Job 6: reset during SEND_STR
    wr_str(8'h68);
    wr_pat(8'h70);
    launch(1'b1);
    tick();
    check("j6_streaming", isstring, 1'b1);
    reset = 1'b1;
    #1;
    check("j6_async_reset", {isstring, busy, res_err, chardata}, '0);
    tick();
    reset = 1'b0;
    tick();
    launch(1'b0);
    check("j6_err_after_reset", {done, res_err}, 2'b11);
    tick();
    check("j6_no_bus", {isstring, ispattern}, 2'b00);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
